// File: rtl/bank_mem_pkg.sv
// rtl/bank_mem_pkg.sv - shared constants, enums and request classifier for bank_mem_ctrl
//   Bank count, address field bounds, request class and bank FSM state enums.
package bank_mem_pkg;

  localparam int NUM_BANKS   = 4;
  localparam int BANK_SEL_HI = 2;
  localparam int BANK_SEL_LO = 1;
  localparam int WORD_HI     = 15;
  localparam int WORD_LO     = 3;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_RD,
    REQ_WR,
    REQ_ERR
  } req_class_e;

  typedef enum logic {
    IDLE,
    BUSY
  } bank_state_e;

  // err outranks everything; stall is decided later against the bank's busy bit.
  function automatic req_class_e classify(input logic rd, input logic wr,
                                          input logic misalign);
    if (!(rd | wr))             return REQ_NONE;
    else if ((rd & wr) | misalign) return REQ_ERR;
    else if (rd)                return REQ_RD;
    else                        return REQ_WR;
  endfunction

endpackage

// File: rtl/mem_bank.sv
// rtl/mem_bank.sv - one interleaved memory bank: storage, busy FSM, read pipe
//   clk, rst        : clock, async active-high reset
//   rd_en, wr_en    : accepted read / write this cycle (never both)
//   word_addr, wdata: bank word address and write data
//   busy            : bank busy, high for BUSY_CYC cycles after an accept
//   rd_valid,rd_data: read return, RD_LAT cycles after the accept; data 0 when not valid
module mem_bank
  import bank_mem_pkg::*;
#(
  parameter int BANK_AW  = 13,
  parameter int BUSY_CYC = 4,
  parameter int RD_LAT   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [BANK_AW-1:0] word_addr,
  input  logic [15:0]        wdata,
  output logic               busy,
  output logic               rd_valid,
  output logic [15:0]        rd_data
);

  logic [15:0] mem [2**BANK_AW];

  bank_state_e state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;

  logic [RD_LAT-1:0] v_pipe;
  logic [15:0]       d_pipe [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Counter holds the remaining busy cycles including the current one.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (rd_en | wr_en) begin
          state_nxt = BUSY;
          cnt_nxt   = 3'(BUSY_CYC);
        end
      end
      BUSY: begin
        if (cnt == 3'd1) begin
          state_nxt = IDLE;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  assign busy = (state == BUSY);

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[word_addr] <= wdata;
  end

  // Data stages carry zero when invalid so the top can simply OR the banks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_pipe <= '0;
      for (int i = 0; i < RD_LAT; i++) d_pipe[i] <= 16'h0000;
    end else begin
      v_pipe[0] <= rd_en;
      d_pipe[0] <= rd_en ? mem[word_addr] : 16'h0000;
      for (int i = 1; i < RD_LAT; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        d_pipe[i] <= d_pipe[i-1];
      end
    end
  end

  assign rd_valid = v_pipe[RD_LAT-1];
  assign rd_data  = d_pipe[RD_LAT-1];

endmodule

// File: rtl/bank_mem_ctrl.sv
// rtl/bank_mem_ctrl.sv - four-bank word-interleaved memory responder
//   clk, rst   : clock, async active-high reset
//   rd, wr     : request strobes; addr byte address (bank addr[2:1], word addr[15:3])
//   data_in    : write data; data_out/rd_valid: registered read return
//   stall      : request held off, bank busy; err: illegal request dropped
//   busy[3:0]  : per-bank busy
//   Optional macro BANK_MEM_ALIGN_CHECK_EN: addr[0]=1 raises err.
module bank_mem_ctrl
  import bank_mem_pkg::*;
#(
  parameter int BANK_AW  = 13,
  parameter int BUSY_CYC = 4,
  parameter int RD_LAT   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd,
  input  logic                 wr,
  input  logic [15:0]          addr,
  input  logic [15:0]          data_in,
  output logic [15:0]          data_out,
  output logic                 rd_valid,
  output logic                 stall,
  output logic [NUM_BANKS-1:0] busy,
  output logic                 err
);

  req_class_e                  req_class;
  logic                        misalign;
  logic [1:0]                  bank_sel;
  logic [NUM_BANKS-1:0]        bank_rd_en, bank_wr_en, bank_vld;
  logic [15:0]                 bank_data [NUM_BANKS];

`ifdef BANK_MEM_ALIGN_CHECK_EN
  assign misalign = addr[0];
`else
  logic unused_addr0;
  assign unused_addr0 = addr[0];
  assign misalign     = 1'b0;
`endif

  assign bank_sel  = addr[BANK_SEL_HI:BANK_SEL_LO];
  assign req_class = classify(rd, wr, misalign);
  assign err       = (req_class == REQ_ERR);
  assign stall     = ((req_class == REQ_RD) || (req_class == REQ_WR)) && busy[bank_sel];

  always_comb begin
    bank_rd_en = '0;
    bank_wr_en = '0;
    if (!stall) begin
      bank_rd_en[bank_sel] = (req_class == REQ_RD);
      bank_wr_en[bank_sel] = (req_class == REQ_WR);
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    mem_bank #(
      .BANK_AW (BANK_AW),
      .BUSY_CYC(BUSY_CYC),
      .RD_LAT  (RD_LAT)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .rd_en    (bank_rd_en[b]),
      .wr_en    (bank_wr_en[b]),
      .word_addr(addr[WORD_LO +: BANK_AW]),
      .wdata    (data_in),
      .busy     (busy[b]),
      .rd_valid (bank_vld[b]),
      .rd_data  (bank_data[b])
    );
  end

  // One request per cycle means at most one bank returns at a time; OR suffices.
  always_comb begin
    data_out = 16'h0000;
    for (int b = 0; b < NUM_BANKS; b++) data_out = data_out | bank_data[b];
  end

  assign rd_valid = |bank_vld;

endmodule
